// File: rtl/stripes_ctrl_pkg.sv
// Shared definitions for the bit-serial inner-product sequencer and its datapath.
package stripes_ctrl_pkg;

  // Maximum neuron precision in bits (equals the synapse width).
  localparam int unsigned NMAX_BITS    = 16;
  // Adder-tree pipeline registers between neuron-bit input and accumulator input.
  localparam int unsigned PIPE_DEFAULT = 1;
  // Field widths of the command interface.
  localparam int unsigned PREC_W       = 5;
  localparam int unsigned BRICK_W      = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } ctrl_state_e;

  // A precision of 0 or above the maximum means "full precision".
  function automatic int unsigned clamp_prec(input int unsigned prec, input int unsigned nmax);
    return ((prec == 0) || (prec > nmax)) ? nmax : prec;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register with a valid lane; tracks in-flight results.
module ctrl_delay_line #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             nonempty_o
);

  logic [Depth-1:0] vld_q;
  logic [Width-1:0] dat_q [Depth];

  // Shift valid and payload one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < Depth; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int i = 1; i < Depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // Payload is only meaningful alongside the strobe, so hold it at zero otherwise.
  always_comb begin
    valid_o    = vld_q[Depth-1];
    data_o     = vld_q[Depth-1] ? dat_q[Depth-1] : '0;
    nonempty_o = |vld_q;
  end

endmodule

// File: rtl/serial_ip_ctrl.sv
// Sequencer for the bit-serial inner-product array: accepts a command, issues neuron bits
// MSB-first brick by brick, and produces accumulator-load and result-valid strobes.
module serial_ip_ctrl
  import stripes_ctrl_pkg::*;
#(
  parameter int unsigned PIPE = PIPE_DEFAULT,
  parameter int unsigned NMAX = NMAX_BITS,
  parameter int unsigned PW   = PREC_W,
  parameter int unsigned BW   = BRICK_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [PW-1:0] i_cmd_prec,
  input  logic [BW-1:0] i_cmd_bricks_m1,
  output logic          o_busy,
  output logic          o_issue,
  output logic [PW-1:0] o_bit_idx,
  output logic          o_first_cycle,
  output logic [BW-1:0] o_brick_idx,
  output logic          o_acc_load,
  output logic          o_psum_zero,
  output logic          o_out_valid,
  output logic          o_out_last
);

  localparam int unsigned DCW = (PIPE > 1) ? $clog2(PIPE) : 1;

  ctrl_state_e   state_q, state_d;
  logic [PW-1:0] prec_q, prec_d;
  logic [PW-1:0] bit_q, bit_d;
  logic [BW-1:0] brick_q, brick_d;
  logic [BW-1:0] bricks_m1_q, bricks_m1_d;
  logic [DCW-1:0] drain_q, drain_d;

  logic [PW-1:0] prec_in;
  logic          more_bricks;
  logic          dl_valid, dl_last, dl_nonempty;

  assign prec_in     = PW'(clamp_prec(32'(i_cmd_prec), NMAX));
  // Brick index saturates at bricks_m1, so an all-ones count never wraps.
  assign more_bricks = (brick_q < bricks_m1_q);

  // State and sequencing counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      prec_q      <= '0;
      bit_q       <= '0;
      brick_q     <= '0;
      bricks_m1_q <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      prec_q      <= prec_d;
      bit_q       <= bit_d;
      brick_q     <= brick_d;
      bricks_m1_q <= bricks_m1_d;
      drain_q     <= drain_d;
    end
  end

  // Next-state: latch command, count bits down, drain the adder tree, advance bricks.
  always_comb begin
    state_d     = state_q;
    prec_d      = prec_q;
    bit_d       = bit_q;
    brick_d     = brick_q;
    bricks_m1_d = bricks_m1_q;
    drain_d     = drain_q;
    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          prec_d      = prec_in;
          bricks_m1_d = i_cmd_bricks_m1;
          bit_d       = prec_in - PW'(1);
          brick_d     = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (bit_q != '0) begin
          bit_d = bit_q - PW'(1);
        end else if (PIPE != 0) begin
          drain_d = DCW'(PIPE - 1);
          state_d = StDrain;
        end else if (more_bricks) begin
          // No tree stages: next brick starts right after bit 0.
          brick_d = brick_q + BW'(1);
          bit_d   = prec_q - PW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (drain_q != '0) begin
          drain_d = drain_q - DCW'(1);
        end else if (more_bricks) begin
          brick_d = brick_q + BW'(1);
          bit_d   = prec_q - PW'(1);
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state; indices read zero when nothing is issued.
  always_comb begin
    o_cmd_ready   = (state_q == StIdle);
    o_issue       = (state_q == StIssue);
    o_bit_idx     = o_issue ? bit_q : '0;
    o_brick_idx   = o_issue ? brick_q : '0;
    o_first_cycle = o_issue && (bit_q == (prec_q - PW'(1)));
    o_acc_load    = o_first_cycle;
    o_psum_zero   = o_acc_load && (brick_q == '0);
    dl_valid      = o_issue && (bit_q == '0);
    dl_last       = (brick_q == bricks_m1_q);
    o_busy        = !o_cmd_ready || dl_nonempty;
  end

  // Bit-0 issue reaches the accumulator PIPE+1 cycles later; tag it with the last-brick flag.
  ctrl_delay_line #(
    .Depth (PIPE + 1),
    .Width (1)
  ) u_delay_line (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (dl_valid),
    .data_i     (dl_last),
    .valid_o    (o_out_valid),
    .data_o     (o_out_last),
    .nonempty_o (dl_nonempty)
  );

endmodule

// File: tb/tb_serial_ip_ctrl.sv
// Bench for serial_ip_ctrl: schedule-based reference model plus directed literal checks.
module tb_serial_ip_ctrl;

  localparam int PIPE = 1;
  localparam int MAXC = 6000;

  localparam int F_ISSUE = 0, F_BIT = 1, F_FIRST = 2, F_LOAD = 3, F_PZ = 4;
  localparam int F_OV = 5, F_LAST = 6, F_BUSY = 7, F_READY = 8, F_BRICK = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [4:0] i_cmd_prec;
  logic [7:0] i_cmd_bricks_m1;
  logic       o_busy, o_issue, o_first_cycle, o_acc_load, o_psum_zero, o_out_valid, o_out_last;
  logic [4:0] o_bit_idx;
  logic [7:0] o_brick_idx;

  serial_ip_ctrl #(.PIPE(PIPE)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_prec      (i_cmd_prec),
    .i_cmd_bricks_m1 (i_cmd_bricks_m1),
    .o_busy          (o_busy),
    .o_issue         (o_issue),
    .o_bit_idx       (o_bit_idx),
    .o_first_cycle   (o_first_cycle),
    .o_brick_idx     (o_brick_idx),
    .o_acc_load      (o_acc_load),
    .o_psum_zero     (o_psum_zero),
    .o_out_valid     (o_out_valid),
    .o_out_last      (o_out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       issue;
    logic [4:0] bit_idx;
    logic       first;
    logic [7:0] brick;
    logic       load;
    logic       pz;
    logic       ov;
    logic       last;
  } obs_t;

  typedef struct {
    int cyc;
    int fld;
    int val;
  } lit_t;

  obs_t exp_q [MAXC];
  lit_t lits[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit   acc_now;

  function automatic obs_t idle_obs();
    obs_t o;
    o       = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic int fld_of(input obs_t o, input int f);
    case (f)
      F_ISSUE: return int'(o.issue);
      F_BIT:   return int'(o.bit_idx);
      F_FIRST: return int'(o.first);
      F_LOAD:  return int'(o.load);
      F_PZ:    return int'(o.pz);
      F_OV:    return int'(o.ov);
      F_LAST:  return int'(o.last);
      F_BUSY:  return int'(o.busy);
      F_READY: return int'(o.ready);
      default: return int'(o.brick);
    endcase
  endfunction

  task automatic model_clear(input int c);
    for (int i = c; i < MAXC; i++) exp_q[i] = idle_obs();
  endtask

  // Expected schedule: brick b starts at c+1+b*(P+PIPE), issues P bits MSB-first,
  // and its result strobes P+PIPE cycles after its first issue.
  task automatic model_accept(input int c, input int p_raw, input int m1);
    int p, per, last_ov;
    p       = ((p_raw == 0) || (p_raw > 16)) ? 16 : p_raw;
    per     = p + PIPE;
    last_ov = c + 1 + (m1 + 1) * per;
    for (int t = c + 1; t <= last_ov && t < MAXC; t++) begin
      exp_q[t].busy = 1'b1;
      if (t < last_ov) exp_q[t].ready = 1'b0;
    end
    for (int b = 0; b <= m1; b++) begin
      int t0;
      t0 = c + 1 + b * per;
      for (int k = 0; k < p; k++) begin
        if (t0 + k < MAXC) begin
          exp_q[t0+k].issue   = 1'b1;
          exp_q[t0+k].bit_idx = 5'(p - 1 - k);
          exp_q[t0+k].brick   = 8'(b);
          exp_q[t0+k].first   = (k == 0);
          exp_q[t0+k].load    = (k == 0);
          exp_q[t0+k].pz      = (k == 0) && (b == 0);
        end
      end
      if (t0 + p + PIPE < MAXC) begin
        exp_q[t0+p+PIPE].ov   = 1'b1;
        exp_q[t0+p+PIPE].last = (b == m1);
      end
    end
  endtask

  task automatic lit(input int c, input int f, input int v);
    lit_t l;
    l.cyc = c;
    l.fld = f;
    l.val = v;
    lits.push_back(l);
  endtask

  task automatic check_cycle();
    obs_t a, e;
    a.ready   = o_cmd_ready;
    a.busy    = o_busy;
    a.issue   = o_issue;
    a.bit_idx = o_bit_idx;
    a.first   = o_first_cycle;
    a.brick   = o_brick_idx;
    a.load    = o_acc_load;
    a.pz      = o_psum_zero;
    a.ov      = o_out_valid;
    a.last    = o_out_last;
    e = exp_q[cyc];
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL cycle %0d outputs: got rdy=%b busy=%b iss=%b bit=%0d fc=%b brick=%0d ld=%b pz=%b ov=%b last=%b / want rdy=%b busy=%b iss=%b bit=%0d fc=%b brick=%0d ld=%b pz=%b ov=%b last=%b",
               cyc, a.ready, a.busy, a.issue, a.bit_idx, a.first, a.brick, a.load, a.pz, a.ov,
               a.last, e.ready, e.busy, e.issue, e.bit_idx, e.first, e.brick, e.load, e.pz, e.ov,
               e.last);
    end
    foreach (lits[i]) begin
      if (lits[i].cyc == cyc) begin
        n_cmp++;
        if (fld_of(a, lits[i].fld) != lits[i].val) begin
          n_bad++;
          $display("FAIL literal cycle %0d field %0d: got %0d want %0d",
                   cyc, lits[i].fld, fld_of(a, lits[i].fld), lits[i].val);
        end
      end
    end
  endtask

  // One cycle: sample at the falling edge, then drive this cycle's command inputs.
  task automatic tick(input bit v, input int p, input int m1, input bit rst_on, input bit rst_off);
    @(negedge clk);
    cyc++;
    acc_now = 1'b0;
    if (rst_on) begin
      reset = 1'b0;
      model_clear(cyc);
      #1;
    end
    check_cycle();
    if (rst_off) reset = 1'b1;
    i_cmd_valid     = v;
    i_cmd_prec      = 5'(p);
    i_cmd_bricks_m1 = 8'(m1);
    if (v && reset && exp_q[cyc].ready) begin
      model_accept(cyc, p, m1);
      acc_now = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic run_cmd(input int p, input int m1, output int base);
    base = -1;
    for (int k = 0; k < 200 && base < 0; k++) begin
      tick(1'b1, p, m1, 1'b0, 1'b0);
      if (acc_now) base = cyc;
    end
    if (base < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_accept: got no acceptance want acceptance within 200 cycles");
      base = cyc;
    end
  endtask

  task automatic push_t1(input int c, input bit b2b);
    lit(c + 1, F_ISSUE, 1);  lit(c + 1, F_BIT, 15);  lit(c + 1, F_FIRST, 1);
    lit(c + 1, F_LOAD, 1);   lit(c + 1, F_PZ, 1);    lit(c + 2, F_FIRST, 0);
    lit(c + 16, F_ISSUE, 1); lit(c + 16, F_BIT, 0);  lit(c + 17, F_ISSUE, 0);
    lit(c + 17, F_OV, 0);    lit(c + 18, F_OV, 1);   lit(c + 18, F_LAST, 1);
    lit(c + 18, F_BUSY, 1);
    if (!b2b) lit(c + 19, F_BUSY, 0);
  endtask

  task automatic push_t2(input int c);
    lit(c + 1, F_LOAD, 1);  lit(c + 6, F_LOAD, 1);  lit(c + 11, F_LOAD, 1);
    lit(c + 1, F_PZ, 1);    lit(c + 6, F_PZ, 0);    lit(c + 11, F_PZ, 0);
    lit(c + 6, F_OV, 1);    lit(c + 11, F_OV, 1);   lit(c + 16, F_OV, 1);
    lit(c + 6, F_LAST, 0);  lit(c + 11, F_LAST, 0); lit(c + 16, F_LAST, 1);
    lit(c + 6, F_BRICK, 1); lit(c + 11, F_BRICK, 2);
  endtask

  initial begin
    int base, b2;
    n_cmp           = 0;
    n_bad           = 0;
    cyc             = -1;
    i_cmd_valid     = 1'b0;
    i_cmd_prec      = '0;
    i_cmd_bricks_m1 = '0;
    model_clear(0);
    reset = 1'b1;
    #2 reset = 1'b0;
    tick(1'b0, 0, 0, 1'b0, 1'b0);
    lit(cyc + 1, F_READY, 1);
    lit(cyc + 1, F_BUSY, 0);
    tick(1'b0, 0, 0, 1'b0, 1'b1);
    idle(2);

    // Full precision, single brick; then clamped precisions.
    run_cmd(16, 0, base); push_t1(base, 1'b0); idle(22);
    run_cmd(0, 0, base);  push_t1(base, 1'b0); idle(22);
    run_cmd(20, 0, base); push_t1(base, 1'b0); idle(22);

    // Three bricks of 4 bits.
    run_cmd(4, 2, base); push_t2(base); idle(20);

    // Single-bit precision, two bricks.
    run_cmd(1, 1, base);
    lit(base + 1, F_ISSUE, 1); lit(base + 1, F_FIRST, 1); lit(base + 1, F_BIT, 0);
    lit(base + 2, F_ISSUE, 0); lit(base + 3, F_ISSUE, 1); lit(base + 3, F_FIRST, 1);
    lit(base + 3, F_OV, 1);    lit(base + 3, F_LAST, 0);  lit(base + 5, F_OV, 1);
    lit(base + 5, F_LAST, 1);
    idle(8);

    // Back-to-back: valid held; second accept lands on the final strobe cycle.
    run_cmd(16, 0, base); push_t1(base, 1'b1);
    lit(base + 17, F_READY, 0); lit(base + 18, F_READY, 1);
    lit(base + 19, F_ISSUE, 1); lit(base + 19, F_FIRST, 1); lit(base + 19, F_BIT, 15);
    for (int i = 0; i < 19; i++) tick(1'b1, 16, 0, 1'b0, 1'b0);
    idle(40);

    // Reset in the middle of a three-brick command.
    run_cmd(4, 2, base);
    idle(9);
    lit(base + 10, F_ISSUE, 0); lit(base + 10, F_READY, 1); lit(base + 10, F_BUSY, 0);
    lit(base + 11, F_OV, 0);    lit(base + 16, F_OV, 0);
    tick(1'b0, 0, 0, 1'b1, 1'b0);
    tick(1'b0, 0, 0, 1'b0, 1'b1);
    idle(3);
    run_cmd(4, 2, b2); push_t2(b2); idle(20);

    // Maximum brick count: index reaches 255 without wrapping.
    run_cmd(1, 255, base);
    lit(base + 1 + 255 * 2, F_BRICK, 255);
    lit(base + 1 + 256 * 2, F_OV, 1);
    lit(base + 1 + 256 * 2, F_LAST, 1);
    lit(base + 1 + 255 * 2, F_OV, 1);
    lit(base + 1 + 255 * 2, F_LAST, 0);
    idle(520);

    // Randomized commands with occasional resets.
    while (cyc < MAXC - 800) begin
      if ($urandom_range(399) == 0) begin
        tick(1'b0, 0, 0, 1'b1, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b1);
      end else begin
        int p, m1;
        p  = int'($urandom_range(31));
        m1 = ($urandom_range(7) == 0) ? int'($urandom_range(15)) : int'($urandom_range(2));
        tick(($urandom_range(3) != 0), p, m1, 1'b0, 1'b0);
      end
    end
    idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
